button_conditioner: RTL and testbench

- Upstream input stage between the board push-button pins (BUT1/BUT2) and the condition inputs of the application core (io_cond0/io_cond1).
- For each asynchronous, bouncy button pin, the block:
  - synchronises it,
  - debounces it,
  - produces a clean level, single-cycle press/release strobes and a single-cycle long-press strobe.
- Replaces the constant tie-offs currently on the core's condition inputs.

---
 rtl/button_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 99 +++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioning front end.
package button_pkg;

   // Default timing for a 12 MHz board clock.
   localparam int unsigned DEBOUNCE_10MS_12MHZ = 120000;
   localparam int unsigned HOLD_1S_12MHZ       = 12000000;

   // Number of bits needed to hold any value in 0..max_value (at least 1).
   function automatic int unsigned cnt_width(input int unsigned max_value);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) <= {32'd0, max_value}) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter, hold counter and
// registered press/release/hold strobes. Level output is normalised to 1 = pressed.
module debounce_channel
   import button_pkg::*;
#(
   parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_12MHZ,
   parameter int unsigned HOLD_CYCLES       = HOLD_1S_12MHZ
) (
   input  logic clk_i,
   input  logic srst_ni,
   input  logic pin_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int unsigned    CNT_W    = cnt_width(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
   // Pin value seen while the button is not pressed.
   localparam logic             PinReleased = BUTTON_ACTIVE_LOW;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             hold_q, hold_d;
   logic             sample;

   // 1 = pressed, independent of pin polarity.
   assign sample = sync2_q ^ BUTTON_ACTIVE_LOW;

   // Next-state: synchroniser shift, debounce acceptance and hold saturation.
   always_comb begin
      sync1_d    = pin_i;
      sync2_d    = sync1_q;
      stable_d   = stable_q;
      deb_cnt_d  = '0;
      press_d    = 1'b0;
      release_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
      hold_d     = 1'b0;

      // A mismatch must persist DEBOUNCE_CYCLES samples; any bounce back restarts at 0.
      if (sample != stable_q) begin
         if (deb_cnt_q == DebLast) begin
            stable_d  = sample;
            press_d   = sample;
            release_d = ~sample;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end

      // Hold only counts while the accepted level is pressed, so a release that
      // lands on the same edge still lets an already-reached count fire.
      if (!stable_q) begin
         hold_cnt_d = '0;
      end else if (hold_cnt_q != HoldMax) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
         hold_d     = (hold_cnt_q == HoldLast);
      end
   end

   // State registers with synchronous active-low reset; reset drops pending transitions.
   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         sync1_q    <= PinReleased;
         sync2_q    <= PinReleased;
         stable_q   <= 1'b0;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         hold_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stable_q   <= stable_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         hold_q     <= hold_d;
      end
   end

   assign level_o   = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign hold_o    = hold_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BUTTONS independent debounce channels feeding the
// core's condition inputs with clean levels and single-cycle event strobes.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS       = 2,
   parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_12MHZ,
   parameter int unsigned HOLD_CYCLES       = HOLD_1S_12MHZ
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] io_buttons,
   output logic [NUM_BUTTONS-1:0] io_level,
   output logic [NUM_BUTTONS-1:0] io_press,
   output logic [NUM_BUTTONS-1:0] io_release,
   output logic [NUM_BUTTONS-1:0] io_hold
);

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      debounce_channel #(
         .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW),
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .HOLD_CYCLES       (HOLD_CYCLES)
      ) u_chan (
         .clk_i     (clk),
         .srst_ni   (reset),
         .pin_i     (io_buttons[g]),
         .level_o   (io_level[g]),
         .press_o   (io_press[g]),
         .release_o (io_release[g]),
         .hold_o    (io_hold[g])
      );
   end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold timing.
module tb_button_conditioner;

   localparam int unsigned Deb  = 8;
   localparam int unsigned Hold = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] io_buttons = 2'b11;
   logic [1:0] io_level, io_press, io_release, io_hold;

   int n_checks = 0;
   int n_errors = 0;

   // Strobe tallies, sampled mid-cycle; tests compare deltas against a snapshot.
   int press_cnt[2]   = '{0, 0};
   int release_cnt[2] = '{0, 0};
   int hold_cnt[2]    = '{0, 0};
   int overlap_cnt    = 0;
   int press_base[2], release_base[2], hold_base[2];

   button_conditioner #(
      .NUM_BUTTONS       (2),
      .BUTTON_ACTIVE_LOW (1'b1),
      .DEBOUNCE_CYCLES   (Deb),
      .HOLD_CYCLES       (Hold)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io_buttons (io_buttons),
      .io_level   (io_level),
      .io_press   (io_press),
      .io_release (io_release),
      .io_hold    (io_hold)
   );

   always #5 clk = ~clk;

   // Tally strobes on the falling edge, away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (io_press[i])   press_cnt[i]++;
         if (io_release[i]) release_cnt[i]++;
         if (io_hold[i])    hold_cnt[i]++;
         if (io_press[i] && io_release[i]) overlap_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Wait n rising edges, then settle 1 ns past the last one.
   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         press_base[i]   = press_cnt[i];
         release_base[i] = release_cnt[i];
         hold_base[i]    = hold_cnt[i];
      end
   endtask

   initial begin
      // Reset with both pins released.
      reset      = 1'b0;
      io_buttons = 2'b11;
      ticks(3);
      check_eq("rst_level",   32'(io_level),   32'd0);
      check_eq("rst_press",   32'(io_press),   32'd0);
      check_eq("rst_release", 32'(io_release), 32'd0);
      check_eq("rst_hold",    32'(io_hold),    32'd0);
      reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         ticks(1);
         check_eq("idle_outs", 32'({io_level, io_press, io_release, io_hold}), 32'd0);
      end

      // Clean press on channel 0: first sampled at edge N, level after N+9.
      io_buttons[0] = 1'b0;
      ticks(9);
      check_eq("clean_lvl_n8",  32'(io_level), 32'd0);
      ticks(1);
      check_eq("clean_lvl_n9",  32'(io_level), 32'b01);
      check_eq("clean_prs_n9",  32'(io_press), 32'b01);
      ticks(1);
      check_eq("clean_prs_n10", 32'(io_press), 32'd0);
      check_eq("clean_lvl_n10", 32'(io_level), 32'b01);

      // Clean release on channel 0.
      io_buttons[0] = 1'b1;
      ticks(9);
      check_eq("rel_lvl_n8", 32'(io_level),   32'b01);
      check_eq("rel_rel_n8", 32'(io_release), 32'd0);
      ticks(1);
      check_eq("rel_lvl_n9", 32'(io_level),   32'd0);
      check_eq("rel_rel_n9", 32'(io_release), 32'b01);
      ticks(1);
      check_eq("rel_rel_n10", 32'(io_release), 32'd0);

      // Bounce: 3-cycle toggles never reach the debounce threshold.
      snap();
      for (int i = 0; i < 10; i++) begin
         io_buttons[0] = 1'(i % 2);
         ticks(3);
      end
      io_buttons[0] = 1'b0;
      ticks(9);
      check_eq("bnc_lvl_n8",  32'(io_level), 32'd0);
      check_eq("bnc_no_strb", 32'(press_cnt[0] - press_base[0] + release_cnt[0] - release_base[0]),
               32'd0);
      ticks(1);
      check_eq("bnc_lvl_n9", 32'(io_level), 32'b01);
      check_eq("bnc_prs_n9", 32'(io_press), 32'b01);
      io_buttons[0] = 1'b1;
      ticks(12);
      check_eq("bnc_rel_lvl", 32'(io_level), 32'd0);
      ticks(1);
      check_eq("bnc_prs_cnt", 32'(press_cnt[0] - press_base[0]),     32'd1);
      check_eq("bnc_rel_cnt", 32'(release_cnt[0] - release_base[0]), 32'd1);

      // Long press on channel 1: hold fires 32 cycles after the level rose.
      snap();
      io_buttons[1] = 1'b0;
      ticks(10);
      check_eq("long_lvl", 32'(io_level), 32'b10);
      check_eq("long_prs", 32'(io_press), 32'b10);
      ticks(31);
      check_eq("long_hold_m31", 32'(io_hold), 32'd0);
      ticks(1);
      check_eq("long_hold_m32", 32'(io_hold),  32'b10);
      check_eq("long_lvl_m32",  32'(io_level), 32'b10);
      ticks(1);
      check_eq("long_hold_m33", 32'(io_hold), 32'd0);
      ticks(17);
      io_buttons[1] = 1'b1;
      ticks(9);
      check_eq("long_rel_r8",   32'(io_release), 32'd0);
      check_eq("long_lvl_r8",   32'(io_level),   32'b10);
      ticks(1);
      check_eq("long_rel_r9",   32'(io_release), 32'b10);
      check_eq("long_lvl_r9",   32'(io_level),   32'd0);
      ticks(2);
      check_eq("long_prs_cnt",  32'(press_cnt[1] - press_base[1]),     32'd1);
      check_eq("long_hold_cnt", 32'(hold_cnt[1] - hold_base[1]),       32'd1);
      check_eq("long_rel_cnt",  32'(release_cnt[1] - release_base[1]), 32'd1);
      check_eq("long_ch0_quiet", 32'(press_cnt[0] - press_base[0]),    32'd0);

      // Short press on channel 0: no hold strobe.
      snap();
      io_buttons[0] = 1'b0;
      ticks(20);
      io_buttons[0] = 1'b1;
      ticks(40);
      check_eq("short_prs_cnt",  32'(press_cnt[0] - press_base[0]),     32'd1);
      check_eq("short_rel_cnt",  32'(release_cnt[0] - release_base[0]), 32'd1);
      check_eq("short_hold_cnt", 32'(hold_cnt[0] - hold_base[0]),       32'd0);
      check_eq("short_lvl",      32'(io_level), 32'd0);

      // Reset while pressed with hold count at 20.
      snap();
      io_buttons[0] = 1'b0;
      ticks(30);
      check_eq("rmid_lvl", 32'(io_level), 32'b01);
      reset = 1'b0;
      ticks(1);
      check_eq("rmid_outs", 32'({io_level, io_press, io_release, io_hold}), 32'd0);
      reset = 1'b1;
      ticks(9);
      check_eq("rmid_lvl_p8", 32'(io_level), 32'd0);
      check_eq("rmid_prs_p8", 32'(io_press), 32'd0);
      ticks(1);
      check_eq("rmid_lvl_p9", 32'(io_level), 32'b01);
      check_eq("rmid_prs_p9", 32'(io_press), 32'b01);
      ticks(1);
      check_eq("rmid_rel_cnt",  32'(release_cnt[0] - release_base[0]), 32'd0);
      check_eq("rmid_hold_cnt", 32'(hold_cnt[0] - hold_base[0]),       32'd0);
      check_eq("rmid_prs_cnt",  32'(press_cnt[0] - press_base[0]),     32'd2);

      io_buttons = 2'b11;
      ticks(15);
      check_eq("end_lvl",     32'(io_level),  32'd0);
      check_eq("no_overlap",  32'(overlap_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_button_conditioner
